watch_set_ctrl: RTL
===================

// Module: watch_set_ctrl
// PURPOSE
//  Mode/entry sequencer for the watch time counter. Collects six keypad digits (HH MM SS) in
//  set mode and validates each one against its position. Commits a complete entry to the
//  counter with a one-cycle load strobe. Gates the counter's run enable and generates its
//  1 Hz tick from the 1 kHz system clock.
// PARAMETERS
//  TICK_DIV     1000   clk cycles per tick_1hz pulse
//  TIMEOUT_CYC  10000  idle clk cycles in EDIT before the entry is abandoned
//  BLINK_DIV    250    clk cycles per blink phase toggle
// PORTS
//  clk         in   1   1 kHz system clock
//  rst         in   1   asynchronous reset, active-high
//  set_mode    in   1   1 = set mode requested (DIP switch, already synchronised)
//  key_valid   in   1   one-cycle pulse: key_digit holds a new digit
//  key_digit   in   4   decimal digit 0..9 (values 10..15 are rejected as invalid)
//  key_clr     in   1   one-cycle pulse: clear entry, restart at position 0
//  load        out  1   one-cycle strobe: counter loads load_time
//  load_time   out  24  BCD {h_ten,h_one,m_ten,m_one,s_ten,s_one}, stable while load=1
//  edit_time   out  24  BCD entry buffer, shown on the display during EDIT
//  cursor      out  3   next digit position 0..5 (0 = h_ten)
//  blink_mask  out  6   bit[5-cursor] = blink phase in EDIT; 0 in all other states
//  run_en      out  1   counter may advance
//  tick_1hz    out  1   one-cycle pulse every TICK_DIV cycles while run_en=1
//  key_err     out  1   one-cycle pulse: digit rejected
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, time_valid=0, all counters 0.
//  run_en = time_valid && state==IDLE.
//  States:
//   IDLE: set_mode=1 -> EDIT. On entry: buffer=0, cursor=0, timeout counter=0.
//   EDIT:
//    - set_mode=0 -> IDLE, no load (abort). Abort wins over a same-cycle key.
//    - key_clr -> buffer=0, cursor=0. key_clr wins over a same-cycle key_valid.
//    - key_valid with a digit valid for the cursor position -> write buffer[cursor],
//      cursor+1. If this was position 5 -> COMMIT.
//    - key_valid with an invalid digit -> key_err=1 next cycle; buffer and cursor unchanged.
//    - Any key_valid or key_clr resets the timeout counter. When the counter reaches
//      TIMEOUT_CYC-1 -> HOLD, no load.
//   COMMIT (1 cycle): load=1, load_time=buffer, time_valid<=1, tick prescaler=0 -> HOLD.
//   HOLD: ignore all keys. set_mode=0 -> IDLE.
//  Per-position digit limits:
//   pos0 <=2;  pos1 <=3 if pos0==2, else <=9;  pos2 <=5;  pos3 <=9;  pos4 <=5;  pos5 <=9.
//   key_clr re-evaluates pos1 against the new pos0.
//  Latency: a valid key_valid updates edit_time/cursor on the next edge. load is asserted
//   on the cycle after the edge that accepted the 6th digit.
//  Tick prescaler: counts only while run_en=1 and holds otherwise. At TICK_DIV-1: wraps to
//   0 and pulses tick_1hz. The first tick after a load arrives exactly TICK_DIV cycles
//   after run_en rises.
//  Blink: phase toggles every BLINK_DIV cycles and is free-running. blink_mask=0 outside
//   EDIT and when cursor==6.
//  Async reset mid-entry: buffer is discarded, time_valid=0, no load pulse.
// TESTING
//  1 Reset, set_mode=0 -> run_en=0, tick_1hz never pulses, all outputs 0.
//  2 set_mode=1, keys 1,2,3,4,5,6 -> single load with load_time=24'h123456; after
//    set_mode=0: run_en=1 and first tick exactly 1000 cycles later.
//  3 set_mode=1, keys 2,4 -> key_err on the '4', cursor stays 1; then key 3 ->
//    edit_time[23:16]=8'h23, cursor=2.
//  4 Keys 1,5 then key_clr with a simultaneous key_valid(7) -> buffer=0, cursor=0, no err.
//  5 Keys 0,9,5 then set_mode=0 -> no load; run_en returns to its prior time_valid value.
//  6 Keys 1,1 then 10000 idle cycles -> HOLD, no load; keys are ignored until set_mode
//    toggles; async rst mid-entry -> outputs 0.

Source files
------------

// File: rtl/watch_set_ctrl.sv
// -----------------------------------------------------------------------------
// watch_set_ctrl
//   Mode/entry sequencer for the watch time counter.
//   - In set mode, collects six keypad digits (HH MM SS) and checks each
//     against the limit for its position.
//   - Sends a complete entry to the counter with a one-cycle load strobe.
//   - Gates the counter's run enable.
//   - Divides the system clock down to the counter's 1 Hz tick.
//
// Ports
//   clk         1 kHz system clock
//   rst         asynchronous reset, active-high
//   set_mode    set mode requested (already synchronised)
//   key_valid   one-cycle pulse, key_digit holds a new digit
//   key_digit   decimal digit 0..9 (10..15 rejected)
//   key_clr     one-cycle pulse, clear the entry and restart at position 0
//   load        one-cycle strobe, counter loads load_time
//   load_time   BCD {h_ten,h_one,m_ten,m_one,s_ten,s_one}, stable while load=1
//   edit_time   BCD entry buffer shown on the display during EDIT
//   cursor      next digit position 0..5 (0 = h_ten)
//   blink_mask  bit[5-cursor] carries the blink phase in EDIT, 0 otherwise
//   run_en      counter may advance
//   tick_1hz    one-cycle pulse every TICK_DIV cycles while run_en=1
//   key_err     one-cycle pulse, digit rejected
//
// Handshake: a key is consumed on the rising edge where key_valid (or
// key_clr) is high. No back-pressure is applied. Keys arriving outside EDIT
// are dropped silently.
// -----------------------------------------------------------------------------
module watch_set_ctrl #(
  parameter int TICK_DIV    = 1000,
  parameter int TIMEOUT_CYC = 10000,
  parameter int BLINK_DIV   = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_mode,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clr,
  output logic        load,
  output logic [23:0] load_time,
  output logic [23:0] edit_time,
  output logic [2:0]  cursor,
  output logic [5:0]  blink_mask,
  output logic        run_en,
  output logic        tick_1hz,
  output logic        key_err
);

  localparam int TICK_W = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BL_W   = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0]   BL_LAST   = BL_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t            state;
  logic              time_valid;
  logic [TICK_W-1:0] presc;
  logic [TO_W-1:0]   idle_cnt;
  logic [BL_W-1:0]   bl_cnt;
  logic              phase;

  logic [3:0]        digit_max;
  logic              digit_ok;
  logic [23:0]       buf_wr;

  // The counter only runs from a committed time and never while the
  // user is editing or holding in set mode.
  assign run_en = time_valid && (state == S_IDLE);

  // Largest digit allowed at the cursor position.
  // The hour units limit depends on the hour tens digit already in the
  // buffer. A clear resets that digit, so the limit is re-evaluated
  // automatically.
  always_comb begin
    digit_max = 4'd9;
    case (cursor)
      3'd0:       digit_max = 4'd2;
      3'd1:       digit_max = (edit_time[23:20] == 4'd2) ? 4'd3 : 4'd9;
      3'd2, 3'd4: digit_max = 4'd5;
      default:    digit_max = 4'd9;
    endcase
  end

  assign digit_ok = (key_digit <= digit_max);

  // Entry buffer with the incoming digit written at the cursor nibble.
  always_comb begin
    buf_wr = edit_time;
    case (cursor)
      3'd0:    buf_wr[23:20] = key_digit;
      3'd1:    buf_wr[19:16] = key_digit;
      3'd2:    buf_wr[15:12] = key_digit;
      3'd3:    buf_wr[11:8]  = key_digit;
      3'd4:    buf_wr[7:4]   = key_digit;
      3'd5:    buf_wr[3:0]   = key_digit;
      default: buf_wr        = edit_time;
    endcase
  end

  // Main sequencer.
  // The tick prescaler lives here because a commit restarts it. That way the
  // first tick lands exactly TICK_DIV cycles after run_en rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      edit_time  <= '0;
      cursor     <= '0;
      idle_cnt   <= '0;
      load       <= 1'b0;
      load_time  <= '0;
      time_valid <= 1'b0;
      presc      <= '0;
      tick_1hz   <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      load    <= 1'b0;
      key_err <= 1'b0;

      if (run_en) begin
        if (presc == TICK_LAST) begin
          presc    <= '0;
          tick_1hz <= 1'b1;
        end else begin
          presc    <= presc + 1'b1;
          tick_1hz <= 1'b0;
        end
      end else begin
        tick_1hz <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (set_mode) begin
            state     <= S_EDIT;
            edit_time <= '0;
            cursor    <= '0;
            idle_cnt  <= '0;
          end
        end

        S_EDIT: begin
          if (!set_mode) begin
            // Abort: leave without loading; a same-cycle key is dropped.
            state <= S_IDLE;
          end else if (key_clr) begin
            edit_time <= '0;
            cursor    <= '0;
            idle_cnt  <= '0;
          end else if (key_valid) begin
            idle_cnt <= '0;
            if (digit_ok) begin
              edit_time <= buf_wr;
              cursor    <= cursor + 3'd1;
              if (cursor == 3'd5) begin
                state      <= S_COMMIT;
                load       <= 1'b1;
                load_time  <= buf_wr;
                time_valid <= 1'b1;
                presc      <= '0;
              end
            end else begin
              key_err <= 1'b1;
            end
          end else if (idle_cnt == TO_LAST) begin
            // Entry abandoned; wait for set_mode to drop.
            state <= S_HOLD;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        // load is high for exactly this one cycle.
        S_COMMIT: state <= S_HOLD;

        S_HOLD: begin
          if (!set_mode) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Free-running blink phase, independent of the sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bl_cnt <= '0;
      phase  <= 1'b0;
    end else if (bl_cnt == BL_LAST) begin
      bl_cnt <= '0;
      phase  <= ~phase;
    end else begin
      bl_cnt <= bl_cnt + 1'b1;
    end
  end

  // Highlight the digit about to be entered. cursor==6 is never held in
  // EDIT, but it is guarded anyway so the shift cannot go out of range.
  always_comb begin
    blink_mask = '0;
    if ((state == S_EDIT) && (cursor <= 3'd5)) begin
      blink_mask = {5'b0, phase} << (3'd5 - cursor);
    end
  end

endmodule
